// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART controller.
// Build option UART_PARITY_EN adds the even-parity state to both FSM encodings.
package uart_pkg;

   localparam int unsigned UART_DATA_W = 8;

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_t;
   typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_t;
`else
   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_t;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;
`endif

   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

   function automatic int unsigned half_bit(input int unsigned cpb);
      return cpb / 2;
   endfunction

endpackage

// File: rtl/uart_if.sv
// CPU-side byte handshake of the UART: write/ready for TX, show-ahead pop/ready for RX.
interface uart_if;
   import uart_pkg::*;

   logic                   uart_w_enable;
   logic [UART_DATA_W-1:0] uart_w_data;
   logic                   uart_w_ready;
   logic                   uart_r_enable;
   logic                   uart_r_ready;
   logic [UART_DATA_W-1:0] uart_r_data;

   modport master (
      output uart_w_enable, uart_w_data, uart_r_enable,
      input  uart_w_ready, uart_r_ready, uart_r_data
   );

   modport slave (
      input  uart_w_enable, uart_w_data, uart_r_enable,
      output uart_w_ready, uart_r_ready, uart_r_data
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; head is driven straight from storage, pointers wrap modulo DEPTH.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [UART_DATA_W-1:0] din,
   output logic [UART_DATA_W-1:0] dout,
   output logic                   empty,
   output logic                   full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

   logic [UART_DATA_W-1:0] mem_q [DEPTH];
   logic [UART_DATA_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW:0]            count_q, count_d;
   logic                   do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == FullCnt);
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && !empty;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      do_push  = push && (!full || do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_ctrl.sv
// Byte-level UART transceiver: TX serialiser, RX deserialiser feeding a show-ahead FIFO.
// Define UART_PARITY_EN for 8E1 framing (even parity bit); default build is 8N1.
module uart_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 25_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  rx,
   output logic  tx,
   uart_if.slave bus,
   output logic  rx_overflow,
   output logic  frame_err
);

   localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned HALF  = half_bit(CPB);
   localparam int unsigned CNT_W = $clog2(CPB);
   localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] HalfLast = CNT_W'(HALF - 1);

   // ---------------- transmitter ----------------
   tx_state_t              tx_state_q, tx_state_d;
   logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d;
   logic [2:0]             tx_bit_q, tx_bit_d;
   logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
   logic                   tx_q, tx_d;
   logic                   tx_bit_end;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_data_d  = tx_data_q;
      tx_bit_end = (tx_cnt_q == BitLast);
      if (tx_state_q != TxIdle) begin
         tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
      end
      unique case (tx_state_q)
         TxIdle: begin
            if (bus.uart_w_enable) begin
               tx_data_d  = bus.uart_w_data;
               tx_state_d = TxStart;
            end
         end
         TxStart: begin
            if (tx_bit_end) begin
               tx_bit_d   = '0;
               tx_state_d = TxData;
            end
         end
         TxData: begin
            if (tx_bit_end) begin
               if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  tx_state_d = TxParity;
`else
                  tx_state_d = TxStop;
`endif
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end
         end
`ifdef UART_PARITY_EN
         TxParity: begin
            if (tx_bit_end) tx_state_d = TxStop;
         end
`endif
         TxStop: begin
            if (tx_bit_end) tx_state_d = TxIdle;
         end
         default: tx_state_d = TxIdle;
      endcase

      // Line level is registered from the next state so the pin never glitches.
      tx_d = 1'b1;
      unique case (tx_state_d)
         TxStart:  tx_d = 1'b0;
         TxData:   tx_d = tx_data_d[tx_bit_d];
`ifdef UART_PARITY_EN
         TxParity: tx_d = ^tx_data_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   assign tx               = tx_q;
   assign bus.uart_w_ready = (tx_state_q == TxIdle);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_data_q  <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_data_q  <= tx_data_d;
         tx_q       <= tx_d;
      end
   end

   // ---------------- receiver ----------------
   logic                   rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_t              rx_state_q, rx_state_d;
   logic [CNT_W-1:0]       rx_cnt_q, rx_cnt_d;
   logic [2:0]             rx_bit_q, rx_bit_d;
   logic [UART_DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic                   rx_push;
   logic                   frame_err_q, frame_err_d;
   logic                   rx_overflow_q, rx_overflow_d;
   logic                   fifo_empty, fifo_full;
`ifdef UART_PARITY_EN
   logic                   rx_par_err_q, rx_par_err_d;
`endif

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_push     = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_PARITY_EN
      rx_par_err_d = rx_par_err_q;
`endif
      if (rx_state_q != RxIdle) begin
         rx_cnt_d = rx_cnt_q + 1'b1;
      end
      unique case (rx_state_q)
         RxIdle: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_cnt_d   = '0;
               rx_state_d = RxStart;
            end
         end
         RxStart: begin
            // Mid start bit: a line already back high was a glitch.
            if (rx_cnt_q == HalfLast) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[UART_DATA_W-1:1]};
               if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  rx_state_d = RxParity;
`else
                  rx_state_d = RxStop;
`endif
               end else begin
                  rx_bit_d = rx_bit_q + 1'b1;
               end
            end
         end
`ifdef UART_PARITY_EN
         RxParity: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d     = '0;
               rx_par_err_d = (rx_sync_q != ^rx_shift_q);
               rx_state_d   = RxStop;
            end
         end
`endif
         RxStop: begin
            if (rx_cnt_q == BitLast) begin
               rx_cnt_d   = '0;
               rx_state_d = RxIdle;
`ifdef UART_PARITY_EN
               if (rx_sync_q && !rx_par_err_q) rx_push = 1'b1;
               else                            frame_err_d = 1'b1;
`else
               if (rx_sync_q) rx_push = 1'b1;
               else           frame_err_d = 1'b1;
`endif
            end
         end
         default: rx_state_d = RxIdle;
      endcase

      rx_overflow_d = rx_overflow_q | (rx_push && fifo_full && !bus.uart_r_enable);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q     <= 1'b1;
         rx_sync_q     <= 1'b1;
         rx_prev_q     <= 1'b1;
         rx_state_q    <= RxIdle;
         rx_cnt_q      <= '0;
         rx_bit_q      <= '0;
         rx_shift_q    <= '0;
         frame_err_q   <= 1'b0;
         rx_overflow_q <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_err_q  <= 1'b0;
`endif
      end else begin
         rx_meta_q     <= rx;
         rx_sync_q     <= rx_meta_q;
         rx_prev_q     <= rx_sync_q;
         rx_state_q    <= rx_state_d;
         rx_cnt_q      <= rx_cnt_d;
         rx_bit_q      <= rx_bit_d;
         rx_shift_q    <= rx_shift_d;
         frame_err_q   <= frame_err_d;
         rx_overflow_q <= rx_overflow_d;
`ifdef UART_PARITY_EN
         rx_par_err_q  <= rx_par_err_d;
`endif
      end
   end

   assign frame_err        = frame_err_q;
   assign rx_overflow      = rx_overflow_q;
   assign bus.uart_r_ready = !fifo_empty;

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (bus.uart_r_enable),
      .din   (rx_shift_q),
      .dout  (bus.uart_r_data),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: frame-level TX model, byte-queue RX model, directed vectors.
module tb_uart_ctrl;

   localparam int unsigned CLK_FREQ = 1_000_000;
   localparam int unsigned BAUD     = 100_000;
   localparam int unsigned DEPTH    = 4;
   localparam int          CPB      = 10;
`ifdef UART_PARITY_EN
   localparam int          FRAME_BITS = 11;
   logic exp_a5 [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
   localparam int          FRAME_BITS = 10;
   logic exp_a5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

   logic clk = 1'b0;
   logic rst;
   logic rx;
   logic tx;
   logic rx_overflow;
   logic frame_err;

   uart_if bus ();

   uart_ctrl #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .tx          (tx),
      .bus         (bus),
      .rx_overflow (rx_overflow),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Line level of bit slot idx of a frame carrying b.
   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UART_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // TX model: tx_k counts cycles since the accepting edge, -1 while idle.
   int         tx_k    = -1;
   logic [7:0] tx_byte = 8'h00;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_k <= -1;
      end else if (tx_k >= 0) begin
         tx_k <= (tx_k + 1 >= FRAME_BITS * CPB) ? -1 : tx_k + 1;
      end else if (bus.uart_w_enable) begin
         tx_k    <= 0;
         tx_byte <= bus.uart_w_data;
      end
   end

   // RX model: queue of bytes the FIFO must hold, plus sticky overflow.
   logic [7:0] rxq[$];
   logic       ovf_m   = 1'b0;
   logic       rx_busy = 1'b0;

   int fe_cnt = 0;
   always @(negedge clk) if (frame_err) fe_cnt <= fe_cnt + 1;

   initial begin : compare
      logic e_tx;
      forever begin
         @(negedge clk);
         e_tx = (tx_k < 0) ? 1'b1 : frame_bit(tx_byte, tx_k / CPB);
         chk("tx_line", 32'(tx), 32'(e_tx));
         chk("w_ready", 32'(bus.uart_w_ready), 32'(tx_k < 0));
         if (!rx_busy) begin
            chk("r_ready", 32'(bus.uart_r_ready), 32'(rxq.size() > 0));
            if (rxq.size() > 0) chk("r_data", 32'(bus.uart_r_data), 32'(rxq[0]));
            chk("rx_overflow", 32'(rx_overflow), 32'(ovf_m));
            chk("frame_err_idle", 32'(frame_err), 32'd0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_tx(input logic [7:0] b);
      bus.uart_w_enable = 1'b1;
      bus.uart_w_data   = b;
      tick(1);
      bus.uart_w_enable = 1'b0;
   endtask

   task automatic pop();
      bus.uart_r_enable = 1'b1;
      tick(1);
      bus.uart_r_enable = 1'b0;
      if (rxq.size() > 0) rxq.delete(0);
   endtask

   // Drives one frame on rx; a good stop bit must push b, a bad one must pulse frame_err once.
   task automatic send_rx(input logic [7:0] b, input logic stop_val);
      int fe0;
      for (int i = 0; i < FRAME_BITS - 1; i++) begin
         rx = frame_bit(b, i);
         tick(CPB);
      end
      rx_busy = 1'b1;
      fe0     = fe_cnt;
      rx      = stop_val;
      tick(CPB);
      rx = 1'b1;
      tick(3);
      if (stop_val) begin
         if (rxq.size() == DEPTH) ovf_m = 1'b1;
         else                     rxq.push_back(b);
      end
      chk("frame_err_pulses", 32'(fe_cnt - fe0), stop_val ? 32'd0 : 32'd1);
      rx_busy = 1'b0;
   endtask

   initial begin : stim
      int fe_before;
      rst               = 1'b0;
      rx                = 1'b1;
      bus.uart_w_enable = 1'b0;
      bus.uart_w_data   = 8'h00;
      bus.uart_r_enable = 1'b0;
      #1 rst = 1'b1;
      tick(2);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_w_ready", 32'(bus.uart_w_ready), 32'd1);
      chk("rst_r_ready", 32'(bus.uart_r_ready), 32'd0);
      chk("rst_r_data", 32'(bus.uart_r_data), 32'd0);
      chk("rst_overflow", 32'(rx_overflow), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      tick(2);

      // TX 0xA5: mid-bit line levels and ready timing.
      write_tx(8'hA5);
      for (int k = 0; k <= FRAME_BITS * CPB; k++) begin
         if (k % CPB == CPB / 2) chk("tx_a5_bit", 32'(tx), 32'(exp_a5[k / CPB]));
         if (k == 0) chk("w_ready_drop", 32'(bus.uart_w_ready), 32'd0);
         if (k == FRAME_BITS * CPB - 1) chk("w_ready_last", 32'(bus.uart_w_ready), 32'd0);
         if (k == FRAME_BITS * CPB) chk("w_ready_back", 32'(bus.uart_w_ready), 32'd1);
         if (k < FRAME_BITS * CPB) tick(1);
      end
      tick(3);

      // Strobe while busy must be ignored; the model expects 0x0F only.
      write_tx(8'h0F);
      tick(30);
      write_tx(8'hFF);
      tick(FRAME_BITS * CPB);
      chk("busy_strobe_ignored", 32'(bus.uart_w_ready), 32'd1);

      // RX 0x3C then pop.
      send_rx(8'h3C, 1'b1);
      chk("rx_3c_ready", 32'(bus.uart_r_ready), 32'd1);
      chk("rx_3c_data", 32'(bus.uart_r_data), 32'h3C);
      pop();
      chk("rx_3c_popped", 32'(bus.uart_r_ready), 32'd0);

      // False start: 3-cycle low glitch.
      fe_before = fe_cnt;
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(2 * FRAME_BITS * CPB);
      chk("false_start_no_push", 32'(bus.uart_r_ready), 32'd0);
      chk("false_start_no_err", 32'(fe_cnt - fe_before), 32'd0);

      // Bad stop bit.
      send_rx(8'h55, 1'b0);
      chk("bad_stop_no_push", 32'(bus.uart_r_ready), 32'd0);
      tick(5);

      // Overflow: five bytes into a 4-deep FIFO.
      for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
      chk("overflow_set", 32'(rx_overflow), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("overflow_order", 32'(bus.uart_r_data), 32'(i));
         pop();
      end
      chk("drained", 32'(bus.uart_r_ready), 32'd0);
      chk("overflow_sticky", 32'(rx_overflow), 32'd1);

      // Pop on empty leaves pointers alone; next byte lands at the head.
      pop();
      tick(2);
      send_rx(8'hC3, 1'b1);
      chk("after_empty_pop", 32'(bus.uart_r_data), 32'hC3);
      pop();
      tick(2);

      // Reset during TX DATA.
      write_tx(8'h96);
      tick(35);
      rst = 1'b1;
      rxq.delete();
      ovf_m = 1'b0;
      #1;
      chk("midrst_tx", 32'(tx), 32'd1);
      chk("midrst_w_ready", 32'(bus.uart_w_ready), 32'd1);
      chk("midrst_overflow", 32'(rx_overflow), 32'd0);
      tick(2);
      rst = 1'b0;
      tick(2);
      write_tx(8'h81);
      tick(FRAME_BITS * CPB + 5);
      chk("post_rst_frame_done", 32'(bus.uart_w_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
